// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Fetch stage sitting directly after the PC/next-PC logic. It owns the
// architectural fetch PC. It keeps at most one instruction-memory request
// outstanding over a req/gnt/rvalid handshake. Each fetched word is handed
// to decode, together with its PC, over a valid/ready handshake.
//
// Branch redirects can arrive in any live state. A redirect that lands
// while a request is outstanding marks that request as squashed, and its
// response is dropped when it returns. A redirect to a target that is not
// word aligned is a fault. A request that is never answered within MAX_WAIT
// cycles is also a fault. Both faults are sticky, and only reset clears them.
//
// Parameters
//   XLEN      width of the PC and of the memory address
//   RESET_PC  fetch PC loaded by reset
//   MAX_WAIT  WAIT cycles allowed without rvalid before a timeout (1..255)
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   redirect_valid   branch taken this cycle
//   redirect_target  new fetch PC for the redirect
//   imem_req         memory request valid (only in REQ)
//   imem_addr        request address, always equal to pc
//   imem_gnt         memory accepted the request this cycle
//   imem_rvalid      read data valid
//   imem_rdata       read data
//   instr_valid      instruction available to decode
//   instr            fetched instruction
//   instr_pc         PC of instr
//   instr_ready      decode accepts instr
//   pc               current fetch PC
//   fetch_fault      sticky fault flag
//   fault_cause      01 = misaligned redirect target, 10 = memory timeout
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     MAX_WAIT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready,
  output logic [XLEN-1:0] pc,
  output logic            fetch_fault,
  output logic [1:0]      fault_cause
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_OUT,
    ST_FAULT
  } state_e;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e          state_q,       state_d;
  logic [XLEN-1:0] pc_q,          pc_d;
  logic [31:0]     instr_q,       instr_d;
  logic [XLEN-1:0] instr_pc_q,    instr_pc_d;
  logic            squash_q,      squash_d;
  logic [7:0]      wait_cnt_q,    wait_cnt_d;
  logic [1:0]      fault_cause_q, fault_cause_d;
  logic            imem_req_q,    imem_req_d;
  logic            instr_valid_q, instr_valid_d;
  logic            fetch_fault_q, fetch_fault_d;

  // A redirect whose target is not word aligned. It beats gnt and rvalid
  // in the same cycle.
  logic bad_redirect;
  assign bad_redirect = redirect_valid && (redirect_target[1:0] != 2'b00);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case, so no path
    // leaves one unassigned and no latch is inferred.
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    squash_d      = squash_q;
    wait_cnt_d    = wait_cnt_q;
    fault_cause_d = fault_cause_q;

    case (state_q)
      ST_IDLE: begin
        if (bad_redirect) begin
          state_d       = ST_FAULT;
          fault_cause_d = CAUSE_MISALIGN;
        end else begin
          if (redirect_valid) begin
            pc_d = redirect_target;
          end
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (bad_redirect) begin
          state_d       = ST_FAULT;
          fault_cause_d = CAUSE_MISALIGN;
        end else if (imem_gnt) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
          if (redirect_valid) begin
            // The memory accepted the old address. Its response must be
            // dropped when it arrives.
            pc_d     = redirect_target;
            squash_d = 1'b1;
          end else begin
            squash_d = 1'b0;
          end
        end else if (redirect_valid) begin
          // The memory accepted nothing, so the request can retarget
          // in place.
          pc_d = redirect_target;
        end
      end

      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (bad_redirect) begin
          state_d       = ST_FAULT;
          fault_cause_d = CAUSE_MISALIGN;
        end else if (redirect_valid) begin
          pc_d = redirect_target;
          if (imem_rvalid) begin
            // The response for the old PC arrives with the redirect. Drop it
            // and fetch the target immediately.
            squash_d = 1'b0;
            state_d  = ST_REQ;
          end else begin
            squash_d = 1'b1;
            if (wait_cnt_d == MAX_WAIT_C) begin
              state_d       = ST_FAULT;
              fault_cause_d = CAUSE_TIMEOUT;
            end
          end
        end else if (imem_rvalid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = ST_REQ;
          end else begin
            instr_d    = imem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + XLEN'(4);
            state_d    = ST_OUT;
          end
        end else if (wait_cnt_d == MAX_WAIT_C) begin
          state_d       = ST_FAULT;
          fault_cause_d = CAUSE_TIMEOUT;
        end
      end

      ST_OUT: begin
        // A redirect in the same cycle as the handshake still counts the
        // instruction as consumed. Either way the next step is a new request.
        if (bad_redirect) begin
          state_d       = ST_FAULT;
          fault_cause_d = CAUSE_MISALIGN;
        end else if (redirect_valid) begin
          pc_d    = redirect_target;
          state_d = ST_REQ;
        end else if (instr_ready) begin
          state_d = ST_REQ;
        end
      end

      ST_FAULT: begin
        // Terminal state. Redirects and responses are ignored until reset.
        state_d = ST_FAULT;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The handshake outputs are registered and are decoded from the next
    // state, so they line up with state_q after the edge.
    imem_req_d    = (state_d == ST_REQ);
    instr_valid_d = (state_d == ST_OUT);
    fetch_fault_d = (state_d == ST_FAULT);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments. Every flop samples the values from
    // before the edge, whatever order the statements are written in.
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      squash_q      <= 1'b0;
      wait_cnt_q    <= '0;
      fault_cause_q <= CAUSE_NONE;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      squash_q      <= squash_d;
      wait_cnt_q    <= wait_cnt_d;
      fault_cause_q <= fault_cause_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_fault = fetch_fault_q;
  assign fault_cause = fault_cause_q;

endmodule
